// File: rtl/multiword_adder_ctrl_if.sv
// multiword_adder_ctrl_if: valid/ready operand and result bundle for multiword_adder_ctrl.
// MULTIWORD_ADDER_CTRL_SUB_EN adds the sub select that travels with the operands.
interface multiword_adder_ctrl_if #(
   parameter int N     = 4,
   parameter int WORDS = 4
);
   localparam int W = N * WORDS;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
`ifdef MULTIWORD_ADDER_CTRL_SUB_EN
   logic         sub;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         c_out;
   logic         busy;
`ifdef MULTIWORD_ADDER_CTRL_SUB_EN
   modport master (output in_valid, a, b, sub, out_ready, input in_ready, out_valid, sum, c_out, busy);
   modport slave  (input in_valid, a, b, sub, out_ready, output in_ready, out_valid, sum, c_out, busy);
`else
   modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, sum, c_out, busy);
   modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, sum, c_out, busy);
`endif
endinterface

// File: rtl/multiword_adder_ctrl.sv
// multiword_adder_ctrl: adds two N*WORDS-bit operands one N-bit chunk per clock, LSB chunk first.
// Define MULTIWORD_ADDER_CTRL_SUB_EN to add a per-operation subtract select.
module multiword_adder_ctrl #(
   parameter int N     = 4,
   parameter int WORDS = 4
) (
   input logic                   clk_i,
   input logic                   rst_ni,
   multiword_adder_ctrl_if.slave bus
);
   localparam int W  = N * WORDS;
   localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          carry_q, carry_d;
   logic          c_out_q, c_out_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  sum_q, sum_d;
   logic [N-1:0]  b_chunk;
   logic [N:0]    chunk;
   logic          last;
`ifdef MULTIWORD_ADDER_CTRL_SUB_EN
   logic          sub_q, sub_d;
   // Subtraction is A + ~B + 1: the +1 is the initial carry loaded at accept.
   assign b_chunk = sub_q ? ~b_q[N-1:0] : b_q[N-1:0];
`else
   assign b_chunk = b_q[N-1:0];
`endif
   assign chunk = {1'b0, a_q[N-1:0]} + {1'b0, b_chunk} + {{N{1'b0}}, carry_q};
   assign last  = cnt_q == CW'(WORDS - 1);
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      c_out_d = c_out_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
`ifdef MULTIWORD_ADDER_CTRL_SUB_EN
      sub_d   = sub_q;
`endif
      if (state_q == IDLE && bus.in_valid) begin
         state_d = RUN;
         cnt_d   = '0;
         a_d     = bus.a;
         b_d     = bus.b;
`ifdef MULTIWORD_ADDER_CTRL_SUB_EN
         sub_d   = bus.sub;
         carry_d = bus.sub;
`else
         carry_d = 1'b0;
`endif
      end else if (state_q == RUN) begin
         a_d     = a_q >> N;
         b_d     = b_q >> N;
         sum_d   = (sum_q >> N) | (W'(chunk[N-1:0]) << (W - N));
         carry_d = chunk[N];
         cnt_d   = cnt_q + CW'(1);
         if (last) begin
            state_d = DONE;
            c_out_d = chunk[N];
         end
      end else if (state_q == DONE && bus.out_ready) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         c_out_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
`ifdef MULTIWORD_ADDER_CTRL_SUB_EN
         sub_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         c_out_q <= c_out_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
`ifdef MULTIWORD_ADDER_CTRL_SUB_EN
         sub_q   <= sub_d;
`endif
      end
   end
   assign bus.in_ready  = state_q == IDLE;
   assign bus.out_valid = state_q == DONE;
   assign bus.busy      = state_q != IDLE;
   assign bus.sum       = sum_q;
   assign bus.c_out     = c_out_q;
endmodule

// File: tb/tb_multiword_adder_ctrl.sv
// tb_multiword_adder_ctrl: directed and randomized checks of multiword_adder_ctrl (N=4, WORDS=4)
// against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_multiword_adder_ctrl;
   localparam int N = 4;
   localparam int WORDS = 4;
   localparam int W = N * WORDS;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int vectors = 0;
   int errs = 0;
   multiword_adder_ctrl_if #(.N(N), .WORDS(WORDS)) bus ();
   multiword_adder_ctrl #(.N(N), .WORDS(WORDS)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // {carry/no-borrow, result} from unsigned arithmetic on the full-width operands
   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      if (sub) return {a >= b, W'(a - b)};
      return {1'b0, a} + {1'b0, b};
   endfunction

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                        output logic [W-1:0] s, output logic c, output int lat);
      bus.a = a;
      bus.b = b;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      repeat (hold) begin
         @(posedge clk); #1;
      end
      s = bus.sum;
      c = bus.c_out;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b1;
      bus.a = 16'h1111;
      bus.b = 16'h2222;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         errs++;
         $display("FAIL reset_flags out_valid=%b busy=%b exp 0 0", bus.out_valid, bus.busy);
      end
      vectors++;
      if (bus.sum !== 16'h0 || bus.c_out !== 1'b0) begin
         errs++;
         $display("FAIL reset_result sum=%h c_out=%b exp 0000 0", bus.sum, bus.c_out);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
         errs++;
         $display("FAIL reset_release in_ready=%b busy=%b exp 1 0", bus.in_ready, bus.busy);
      end
   endtask

   task automatic test_basic();
      int lat = -1;
      int busy_cnt = 0;
      logic [W-1:0] s = '0;
      logic c = 1'b0;
      bus.a = 16'h1234;
      bus.b = 16'h4321;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      vectors++;
      if (bus.in_ready !== 1'b0) begin
         errs++;
         $display("FAIL basic_in_ready_after_accept got %b exp 0", bus.in_ready);
      end
      for (int e = 0; e < 10; e++) begin
         if (bus.busy) busy_cnt++;
         if (bus.out_valid && lat < 0) begin
            lat = e;
            s = bus.sum;
            c = bus.c_out;
         end
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b0;
      vectors++;
      if (lat !== 4) begin
         errs++;
         $display("FAIL basic_latency got %0d exp 4", lat);
      end
      vectors++;
      if (s !== 16'h5555 || c !== 1'b0) begin
         errs++;
         $display("FAIL basic_sum got %h/%b exp 5555/0", s, c);
      end
      vectors++;
      if (busy_cnt !== 5) begin
         errs++;
         $display("FAIL basic_busy_cycles got %0d exp 5", busy_cnt);
      end
   endtask

   task automatic test_carry();
      logic [W-1:0] s;
      logic c;
      int lat;
      do_op(16'hFFFF, 16'h0001, 0, s, c, lat);
      vectors++;
      if (s !== 16'h0000 || c !== 1'b1 || lat !== 4) begin
         errs++;
         $display("FAIL carry_ffff got %h/%b lat %0d exp 0000/1 lat 4", s, c, lat);
      end
      do_op(16'h8000, 16'h8000, 0, s, c, lat);
      vectors++;
      if (s !== 16'h0000 || c !== 1'b1) begin
         errs++;
         $display("FAIL carry_8000 got %h/%b exp 0000/1", s, c);
      end
   endtask

   task automatic test_backpressure();
      int lat = 0;
      bus.a = 16'h00FF;
      bus.b = 16'h0001;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      bus.a = 16'h1111;
      bus.b = 16'h1111;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (bus.out_valid !== 1'b1 || bus.sum !== 16'h0100 || bus.in_ready !== 1'b0) begin
            errs++;
            $display("FAIL bp_hold[%0d] out_valid=%b sum=%h in_ready=%b exp 1 0100 0",
                     i, bus.out_valid, bus.sum, bus.in_ready);
         end
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errs++;
         $display("FAIL bp_release out_valid=%b in_ready=%b exp 0 1", bus.out_valid, bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      vectors++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
         errs++;
         $display("FAIL bp_second_accept busy=%b in_ready=%b exp 1 0", bus.busy, bus.in_ready);
      end
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      vectors++;
      if (bus.sum !== 16'h2222 || bus.c_out !== 1'b0 || lat !== 4) begin
         errs++;
         $display("FAIL bp_second_sum got %h/%b lat %0d exp 2222/0 lat 4", bus.sum, bus.c_out, lat);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      logic [W-1:0] s;
      logic c;
      int lat;
      bus.a = 16'hABCD;
      bus.b = 16'h1111;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.sum !== 16'h0 || bus.c_out !== 1'b0 || bus.busy !== 1'b0) begin
         errs++;
         $display("FAIL midrun_reset out_valid=%b sum=%h c_out=%b busy=%b exp 0 0000 0 0",
                  bus.out_valid, bus.sum, bus.c_out, bus.busy);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errs++;
         $display("FAIL midrun_release in_ready=%b out_valid=%b exp 1 0", bus.in_ready, bus.out_valid);
      end
      do_op(16'h0F0F, 16'h00F1, 0, s, c, lat);
      vectors++;
      if (s !== 16'h1000 || c !== 1'b0 || lat !== 4) begin
         errs++;
         $display("FAIL midrun_after got %h/%b lat %0d exp 1000/0 lat 4", s, c, lat);
      end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      int vc[2];
      logic [W-1:0] vs[2];
      logic seen_idle = 1'b0;
      bus.a = 16'h0001;
      bus.b = 16'h0001;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.a = 16'h7FFF;
      bus.b = 16'h0001;
      for (int e = 0; e < 16; e++) begin
         if (bus.out_valid && n < 2) begin
            vc[n] = e;
            vs[n] = bus.sum;
            n++;
         end
         if (bus.in_ready) seen_idle = 1'b1;
         else if (seen_idle) bus.in_valid = 1'b0;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      vectors++;
      if (n !== 2) begin
         errs++;
         $display("FAIL b2b_count got %0d exp 2", n);
      end else begin
         vectors++;
         if (vs[0] !== 16'h0002 || vs[1] !== 16'h8000) begin
            errs++;
            $display("FAIL b2b_sums got %h %h exp 0002 8000", vs[0], vs[1]);
         end
         vectors++;
         if (vc[1] - vc[0] !== 6) begin
            errs++;
            $display("FAIL b2b_spacing got %0d exp 6", vc[1] - vc[0]);
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, s;
      logic c, sub;
      logic [W:0] exp;
      int lat;
      for (int i = 0; i < 40; i++) begin
         a = W'($urandom);
         b = W'($urandom);
`ifdef MULTIWORD_ADDER_CTRL_SUB_EN
         sub = 1'($urandom);
         bus.sub = sub;
`else
         sub = 1'b0;
`endif
         exp = model(a, b, sub);
         do_op(a, b, $urandom_range(0, 3), s, c, lat);
         vectors++;
         if ({c, s} !== exp || lat !== 4) begin
            errs++;
            $display("FAIL rand[%0d] %h op%0d %h got %b/%h lat %0d exp %b/%h lat 4",
                     i, a, sub, b, c, s, lat, exp[W], exp[W-1:0]);
         end
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
`ifdef MULTIWORD_ADDER_CTRL_SUB_EN
      bus.sub = 1'b0;
`endif
   endtask

`ifdef MULTIWORD_ADDER_CTRL_SUB_EN
   task automatic test_sub();
      logic [W-1:0] s;
      logic c;
      int lat;
      bus.sub = 1'b1;
      do_op(16'h0005, 16'h0007, 0, s, c, lat);
      vectors++;
      if (s !== 16'hFFFE || c !== 1'b0) begin
         errs++;
         $display("FAIL sub_borrow got %h/%b exp fffe/0", s, c);
      end
      do_op(16'h0007, 16'h0005, 0, s, c, lat);
      vectors++;
      if (s !== 16'h0002 || c !== 1'b1) begin
         errs++;
         $display("FAIL sub_noborrow got %h/%b exp 0002/1", s, c);
      end
      bus.sub = 1'b0;
      do_op(16'h0005, 16'h0007, 0, s, c, lat);
      vectors++;
      if (s !== 16'h000C || c !== 1'b0) begin
         errs++;
         $display("FAIL sub_off_add got %h/%b exp 000c/0", s, c);
      end
   endtask
`endif

   initial begin
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.a = '0;
      bus.b = '0;
`ifdef MULTIWORD_ADDER_CTRL_SUB_EN
      bus.sub = 1'b0;
`endif
      test_reset();
      test_basic();
      test_carry();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      test_random();
`ifdef MULTIWORD_ADDER_CTRL_SUB_EN
      test_sub();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/multiword_adder_ctrl.md
Name: multiword_adder_ctrl

Overview:
- Sequencer that adds two wide operands (N*WORDS bits) with a single N-bit adder slice.
- Processes one N-bit chunk per clock, least-significant chunk first, and carries between chunks in a register.
- Sits between a valid/ready producer and a valid/ready consumer, so wide additions run without a wide ripple chain.

Parameters:
- N, 4, width of the adder slice (chunk width), >=1
- WORDS, 4, number of chunks per operand, >=1; operand/result width W = N*WORDS

Ports:
- CLK  input  1  clock, rising edge
- RST_N  input  1  asynchronous active-low reset
- IN_VALID  input  1  operands A,B valid
- IN_READY  output  1  block can accept operands
- A  input  W  operand A
- B  input  W  operand B
- OUT_VALID  output  1  SUM/C_OUT valid
- OUT_READY  input  1  consumer accepts result
- SUM  output  W  result, A+B mod 2^W
- C_OUT  output  1  carry out of the most-significant chunk
- BUSY  output  1  high in RUN and DONE states

Behaviour:
- Clock and reset: one clock, CLK; reset RST_N is asynchronous, active-low.
- Reset (RST_N=0, any time including mid-operation):
  - state=IDLE, chunk counter=0, carry reg=0
  - operand shift regs=0, SUM=0, C_OUT=0, OUT_VALID=0, BUSY=0
  - IN_READY=1 as soon as reset releases
  - Any in-flight operation is discarded; no partial result is ever flagged valid.
- States: IDLE, RUN, DONE. Encoding is free; IN_READY = (state==IDLE) and OUT_VALID = (state==DONE), both decoded from registered state.
- IDLE:
  - On IN_VALID & IN_READY at an edge: latch A,B into shift registers, carry=0, counter=0, go to RUN.
  - Otherwise hold. SUM/C_OUT keep the last result.
- RUN, one chunk per cycle:
  - {c, s} = A_reg[N-1:0] + B_reg[N-1:0] + carry, computed (N+1) bits wide.
  - SUM shifts right by N with s entering at SUM[W-1:W-N].
  - A_reg and B_reg shift right by N. carry=c.
  - counter increments; when counter==WORDS-1 at the edge, go to DONE and set C_OUT=c.
  - Counter width is max(1, clog2(WORDS)). It must not wrap before the terminal compare; WORDS=1 gives one RUN cycle.
  - IN_VALID is ignored in RUN.
- DONE:
  - OUT_VALID=1. SUM and C_OUT are stable while OUT_READY=0 (backpressure of any length).
  - On OUT_READY=1 at an edge: go to IDLE. OUT_VALID drops and IN_READY rises after that edge.
  - IN_VALID is ignored in DONE; there is no bypass from DONE straight to RUN.
- Latency: OUT_VALID rises WORDS edges after the accept edge.
- Throughput: with IN_VALID and OUT_READY held high, one result every WORDS+2 cycles.
- IN_VALID/OUT_READY asserted during reset are ignored. The first accept is possible on the first edge after RST_N deasserts.
- Arithmetic is unsigned modulo 2^W; overflow is reported only through C_OUT.

Optional Feature:
- Macro: MULTIWORD_ADDER_CTRL_SUB_EN.
- Defined:
  - Adds input port SUB (1 bit), sampled with A,B at the accept edge and held internally for the whole operation.
  - SUB=1: each chunk uses ~B_reg chunk and the initial carry is 1, so SUM = A-B mod 2^W. C_OUT=1 means no borrow (A>=B); C_OUT=0 means borrow.
  - SUB=0: identical to the plain adder.
- Not defined: no SUB port, addition only, no extra logic.

Test Plan (N=4, WORDS=4, W=16):
- 0x1234+0x4321, OUT_READY=1 -> OUT_VALID high 4 edges after accept, SUM=0x5555, C_OUT=0, BUSY high for 5 cycles.
- 0xFFFF+0x0001 -> SUM=0x0000, C_OUT=1 (carry propagates through all 4 chunks); 0x8000+0x8000 -> SUM=0x0000, C_OUT=1.
- Backpressure: result 0x00FF+0x0001, OUT_READY=0 for 6 cycles -> SUM=0x0100 and OUT_VALID=1 stable throughout; IN_READY=0; a new IN_VALID with 0x1111+0x1111 is not accepted until after the OUT_READY handshake.
- Reset mid-RUN: assert RST_N=0 after 2 chunks of 0xABCD+0x1111 -> immediately OUT_VALID=0, SUM=0, C_OUT=0, IN_READY=1 after release; then 0x0F0F+0x00F1 -> SUM=0x1000, C_OUT=0.
- Back-to-back stream: IN_VALID and OUT_READY held high, operands 0x0001+0x0001 and then 0x7FFF+0x0001 -> results 0x0002 and 0x8000, OUT_VALID pulses 6 cycles apart.
- With MULTIWORD_ADDER_CTRL_SUB_EN:
  - SUB=1, 0x0005-0x0007 -> SUM=0xFFFE, C_OUT=0.
  - SUB=1, 0x0007-0x0005 -> SUM=0x0002, C_OUT=1.
  - SUB=0, 0x0005+0x0007 -> SUM=0x000C.
